// File: rtl/feed_pkg.sv
// Shared types and constants for the feed scheduler and its servo PWM generator.
package feed_pkg;
  typedef enum logic {IDLE = 1'b0, FEED = 1'b1} state_e;

  localparam int NUM_SLOTS = 3;
  localparam logic [1:0] MANUAL_SLOT = 2'd3;
  localparam int HOUR_W = 8;
  localparam int MIN_W = 8;
  localparam int AMPM_W = 1;

  // Lowest-index set bit wins when several slots fire together.
  function automatic logic [1:0] first_slot(input logic [NUM_SLOTS-1:0] trig);
    if (trig[0]) return 2'd0;
    else if (trig[1]) return 2'd1;
    else return 2'd2;
  endfunction
endpackage

// File: rtl/feed_scheduler_servo_pwm.sv
// Servo frame generator: free-running frame counter, pulse width latched at frame start.
// With FEED_SW_OVERRIDE_EN defined, software can drive the pin directly.
module servo_pwm
  import feed_pkg::*;
#(
  parameter int PWM_PERIOD   = 1_000_000,
  parameter int PULSE_OPEN   = 100_000,
  parameter int PULSE_CLOSED = 50_000
) (
  input  logic clock,
  input  logic reset,
  input  logic open,
`ifdef FEED_SW_OVERRIDE_EN
  input  logic sw_pwm,
  input  logic sw_override,
`endif
  output logic motor_pwm
);
  localparam int CNT_W = $clog2(PWM_PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PWM_PERIOD - 1);
  localparam logic [CNT_W-1:0] W_OPEN     = CNT_W'(PULSE_OPEN);
  localparam logic [CNT_W-1:0] W_CLOSED   = CNT_W'(PULSE_CLOSED);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pulse_q, pulse_d;
  logic             motor_q, motor_d;

  always_comb begin
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    // Width only changes on a frame boundary so a frame is never cut short.
    pulse_d = (cnt_q == '0) ? (open ? W_OPEN : W_CLOSED) : pulse_q;
    motor_d = (cnt_q < pulse_q);
`ifdef FEED_SW_OVERRIDE_EN
    if (sw_override) motor_d = sw_pwm;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      pulse_q <= W_CLOSED;
      motor_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      motor_q <= motor_d;
    end
  end

  assign motor_pwm = motor_q;
endmodule

// File: rtl/feed_scheduler.sv
// Feed scheduler: fires a timed motor run on slot-time match or manual request.
// Optional FEED_SW_OVERRIDE_EN adds a software override of the motor pin.
module feed_scheduler
  import feed_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter int PWM_PERIOD   = 1_000_000,
  parameter int PULSE_OPEN   = 100_000,
  parameter int PULSE_CLOSED = 50_000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [HOUR_W-1:0]             cur_hour,
  input  logic [MIN_W-1:0]              cur_min,
  input  logic [AMPM_W-1:0]             cur_ampm,
  input  logic [NUM_SLOTS*HOUR_W-1:0]   slot_hour,
  input  logic [NUM_SLOTS*MIN_W-1:0]    slot_min,
  input  logic [NUM_SLOTS*AMPM_W-1:0]   slot_ampm,
  input  logic [NUM_SLOTS-1:0]          slot_en,
  input  logic [31:0]                   duration,
  input  logic                          manual_feed,
`ifdef FEED_SW_OVERRIDE_EN
  input  logic                          sw_pwm,
  input  logic                          sw_override,
`endif
  output logic                          motor_pwm,
  output logic                          feeding,
  output logic [1:0]                    active_slot,
  output logic [7:0]                    feed_count,
  output state_e                        dbg_state
);
  localparam int TICK_W = $clog2(TICK_DIV + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  state_e               state_q, state_d;
  logic [NUM_SLOTS-1:0] match, trig, match_q, match_d;
  logic [31:0]          dur_q, dur_d;
  logic [31:0]          sec_q, sec_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [1:0]           slot_q, slot_d;
  logic [7:0]           count_q, count_d;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      match[i] = slot_en[i]
              && (slot_hour[i*HOUR_W +: HOUR_W] == cur_hour)
              && (slot_min[i*MIN_W +: MIN_W] == cur_min)
              && (slot_ampm[i*AMPM_W +: AMPM_W] == cur_ampm);
    end
    // Rising edge of a match, so a slot fires once per matching minute.
    trig    = match & ~match_q;
    match_d = match;
    state_d = state_q;
    dur_d   = dur_q;
    sec_d   = sec_q;
    tick_d  = tick_q;
    slot_d  = slot_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if ((trig != '0) || manual_feed) begin
          state_d = FEED;
          dur_d   = (duration == 32'd0) ? 32'd1 : duration;
          sec_d   = '0;
          tick_d  = '0;
          slot_d  = (trig != '0) ? first_slot(trig) : MANUAL_SLOT;
          count_d = count_q + 8'd1;
        end
      end
      FEED: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          sec_d  = sec_q + 32'd1;
          if (sec_q + 32'd1 == dur_q) state_d = IDLE;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      match_q <= '1;
      dur_q   <= 32'd1;
      sec_q   <= '0;
      tick_q  <= '0;
      slot_q  <= 2'd0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      dur_q   <= dur_d;
      sec_q   <= sec_d;
      tick_q  <= tick_d;
      slot_q  <= slot_d;
      count_q <= count_d;
    end
  end

  assign feeding     = (state_q == FEED);
  assign active_slot = slot_q;
  assign feed_count  = count_q;
  assign dbg_state   = state_q;

  servo_pwm #(
    .PWM_PERIOD  (PWM_PERIOD),
    .PULSE_OPEN  (PULSE_OPEN),
    .PULSE_CLOSED(PULSE_CLOSED)
  ) u_servo_pwm (
    .clock      (clock),
    .reset      (reset),
    .open       (state_q == FEED),
`ifdef FEED_SW_OVERRIDE_EN
    .sw_pwm     (sw_pwm),
    .sw_override(sw_override),
`endif
    .motor_pwm  (motor_pwm)
  );
endmodule

// File: tb/tb_feed_scheduler.sv
// Directed bench for feed_scheduler with a per-cycle behavioural model of feeds and servo frames.
module tb_feed_scheduler;
  import feed_pkg::*;

  localparam int TICK_DIV = 10;
  localparam int PWM_PERIOD = 20;
  localparam int PULSE_OPEN = 4;
  localparam int PULSE_CLOSED = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  cur_hour = 8'd0;
  logic [7:0]  cur_min = 8'd0;
  logic        cur_ampm = 1'b0;
  logic [23:0] slot_hour = '0;
  logic [23:0] slot_min = '0;
  logic [2:0]  slot_ampm = '0;
  logic [2:0]  slot_en = '0;
  logic [31:0] duration = 32'd0;
  logic        manual_feed = 1'b0;
  logic        sw_pwm = 1'b0;
  logic        sw_override = 1'b0;
  logic        motor_pwm;
  logic        feeding;
  logic [1:0]  active_slot;
  logic [7:0]  feed_count;
  state_e      dbg_state;

  int errors = 0;
  int checks = 0;
  int feed_cycles = 0;

  // Model state
  logic        m_feeding = 1'b0;
  logic [1:0]  m_slot = 2'd0;
  logic [7:0]  m_count = 8'd0;
  logic [2:0]  m_prev_match = 3'b111;
  logic [31:0] m_remaining = 32'd0;
  int          m_edges = 0;
  int          m_frame_w = PULSE_CLOSED;
  logic        m_motor = 1'b0;

  feed_scheduler #(
    .TICK_DIV(TICK_DIV), .PWM_PERIOD(PWM_PERIOD),
    .PULSE_OPEN(PULSE_OPEN), .PULSE_CLOSED(PULSE_CLOSED)
  ) dut (
    .clock(clock), .reset(reset),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_ampm(cur_ampm),
    .slot_hour(slot_hour), .slot_min(slot_min), .slot_ampm(slot_ampm),
    .slot_en(slot_en), .duration(duration), .manual_feed(manual_feed),
`ifdef FEED_SW_OVERRIDE_EN
    .sw_pwm(sw_pwm), .sw_override(sw_override),
`endif
    .motor_pwm(motor_pwm), .feeding(feeding), .active_slot(active_slot),
    .feed_count(feed_count), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one step per rising edge, using the inputs that edge saw.
  task automatic model_step();
    logic [2:0] match;
    logic [2:0] trig;
    logic       old_feed;
    int         phase;
    if (reset) begin
      m_feeding = 1'b0; m_slot = 2'd0; m_count = 8'd0; m_prev_match = 3'b111;
      m_remaining = 0; m_edges = 0; m_frame_w = PULSE_CLOSED; m_motor = 1'b0;
      return;
    end
    for (int i = 0; i < 3; i++)
      match[i] = slot_en[i] && slot_hour[i*8 +: 8] == cur_hour &&
                 slot_min[i*8 +: 8] == cur_min && slot_ampm[i] == cur_ampm;
    trig = match & ~m_prev_match;
    m_prev_match = match;
    old_feed = m_feeding;
    if (m_feeding) begin
      m_remaining = m_remaining - 1;
      if (m_remaining == 0) m_feeding = 1'b0;
    end else if (trig != 0 || manual_feed) begin
      m_feeding = 1'b1;
      m_count = m_count + 8'd1;
      m_remaining = ((duration == 0) ? 32'd1 : duration) * TICK_DIV;
      if (trig[0]) m_slot = 2'd0;
      else if (trig[1]) m_slot = 2'd1;
      else if (trig[2]) m_slot = 2'd2;
      else m_slot = 2'd3;
    end
    phase = m_edges % PWM_PERIOD;
    if (phase == 0) m_frame_w = old_feed ? PULSE_OPEN : PULSE_CLOSED;
    m_motor = (phase < m_frame_w);
`ifdef FEED_SW_OVERRIDE_EN
    if (sw_override) m_motor = sw_pwm;
`endif
    m_edges++;
  endtask

  // Scoreboard: compare every cycle just after the active edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      model_step();
      check("feeding", {31'd0, feeding}, {31'd0, m_feeding});
      check("dbg_state", {31'd0, dbg_state == FEED}, {31'd0, m_feeding});
      check("feed_count", {24'd0, feed_count}, {24'd0, m_count});
      check("motor_pwm", {31'd0, motor_pwm}, {31'd0, m_motor});
      if (m_feeding) check("active_slot", {30'd0, active_slot}, {30'd0, m_slot});
      if (feeding) feed_cycles++;
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic ap);
    @(negedge clock);
    cur_hour = h; cur_min = m; cur_ampm = ap;
  endtask

  task automatic pulse_manual();
    @(negedge clock);
    manual_feed = 1'b1;
    @(negedge clock);
    manual_feed = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (feeding && n < max_cycles) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (feeding) begin
      errors++;
      $display("FAIL wait_idle: feeding still high after %0d cycles", max_cycles);
    end
  endtask

  task automatic count_highs(input int n, output int highs);
    highs = 0;
    repeat (n) begin
      highs += motor_pwm;
      @(negedge clock);
    end
  endtask

  int highs;

  initial begin
    // Slot1 = 7:30 PM, slot2 = 9:00 AM, slot3 = 7:30 PM.
    slot_hour = {8'd7, 8'd9, 8'd7};
    slot_min  = {8'd30, 8'd0, 8'd30};
    slot_ampm = 3'b101;
    tick(3);
    check("rst_feeding", {31'd0, feeding}, 32'd0);
    check("rst_count", {24'd0, feed_count}, 32'd0);
    check("rst_motor", {31'd0, motor_pwm}, 32'd0);
    check("rst_slot", {30'd0, active_slot}, 32'd0);
    reset = 1'b0;
    tick(1);
    check("first_pwm_high", {31'd0, motor_pwm}, 32'd1);
    tick(30);

    // Single scheduled slot, 3-second feed, no refire within the minute.
    slot_en = 3'b001; duration = 32'd3; feed_cycles = 0;
    set_time(8'd7, 8'd30, 1'b1);
    tick(1);
    check("s1_feeding", {31'd0, feeding}, 32'd1);
    check("s1_slot", {30'd0, active_slot}, 32'd0);
    tick(80);
    check("s1_cycles", feed_cycles, 32'd30);
    check("s1_count", {24'd0, feed_count}, 32'd1);
    set_time(8'd7, 8'd31, 1'b1);
    tick(5);

    // Slots 1 and 3 plus manual in the same cycle: slot 0 wins, one feed.
    slot_en = 3'b101; feed_cycles = 0;
    @(negedge clock);
    cur_min = 8'd30; manual_feed = 1'b1;
    @(negedge clock);
    manual_feed = 1'b0;
    check("s2_slot", {30'd0, active_slot}, 32'd0);
    tick(80);
    check("s2_cycles", feed_cycles, 32'd30);
    check("s2_count", {24'd0, feed_count}, 32'd2);
    set_time(8'd7, 8'd31, 1'b1);
    tick(5);

    // Manual during FEED is dropped; manual with duration 0 runs one second.
    duration = 32'd2; feed_cycles = 0;
    pulse_manual();
    tick(5);
    pulse_manual();
    wait_idle(60);
    tick(3);
    check("s3a_cycles", feed_cycles, 32'd20);
    check("s3a_count", {24'd0, feed_count}, 32'd3);
    duration = 32'd0; feed_cycles = 0;
    pulse_manual();
    check("s3b_feeding", {31'd0, feeding}, 32'd1);
    check("s3b_slot", {30'd0, active_slot}, 32'd3);
    wait_idle(40);
    tick(3);
    check("s3b_cycles", feed_cycles, 32'd10);
    check("s3b_count", {24'd0, feed_count}, 32'd4);

    // PWM widths: 4 highs per frame inside a long feed, 2 when idle.
    duration = 32'd5;
    pulse_manual();
    tick(20);
    count_highs(20, highs);
    check("pwm_open_highs", highs, 32'd4);
    wait_idle(80);
    tick(25);
    count_highs(20, highs);
    check("pwm_closed_highs", highs, 32'd2);

    // Reset mid-feed with the time still matching: no refire until the minute changes.
    slot_en = 3'b001; duration = 32'd3;
    set_time(8'd7, 8'd30, 1'b1);
    tick(5);
    check("s4_feeding_pre", {31'd0, feeding}, 32'd1);
    reset = 1'b1;
    tick(2);
    check("s4_rst_feeding", {31'd0, feeding}, 32'd0);
    check("s4_rst_count", {24'd0, feed_count}, 32'd0);
    check("s4_rst_motor", {31'd0, motor_pwm}, 32'd0);
    reset = 1'b0;
    tick(50);
    check("s4_no_refire", {24'd0, feed_count}, 32'd0);
    set_time(8'd7, 8'd31, 1'b1);
    tick(2);
    set_time(8'd7, 8'd30, 1'b1);
    tick(2);
    check("s4_refire", {31'd0, feeding}, 32'd1);
    check("s4_count", {24'd0, feed_count}, 32'd1);
    wait_idle(60);
    set_time(8'd7, 8'd31, 1'b1);
    tick(5);

`ifdef FEED_SW_OVERRIDE_EN
    // Software override: pin follows sw_pwm one cycle later, scheduler keeps counting.
    @(negedge clock);
    sw_override = 1'b1; sw_pwm = 1'b1;
    @(negedge clock);
    check("ovr_high", {31'd0, motor_pwm}, 32'd1);
    sw_pwm = 1'b0;
    @(negedge clock);
    check("ovr_low", {31'd0, motor_pwm}, 32'd0);
    cur_min = 8'd30;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      sw_pwm = 1'($urandom_range(0, 1));
    end
    check("ovr_count", {24'd0, feed_count}, 32'd2);
    wait_idle(40);
    @(negedge clock);
    sw_override = 1'b0;
    tick(25);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
